alu_program_sequencer: RTL

- Runs a short stored program through the existing register-file + ALU datapath without operator keypresses.
- Fetches 16-bit instructions from a synchronous instruction ROM and decodes them in the standard format:
  - IMM = bit 15
  - SR1 = [14:11]
  - SR2/IMM4 = [10:7]
  - opcode = [6:5]
  - DR = [4:1]
  - OPM = bit 0
- Drives register-file addresses, ALU controls and writeback, and stops on overflow, on the halt word or at end of program.
- Sits between the top-level mode FSM and the RAM_Register/ALU/Output_Multiplexer datapath.

---
 rtl/alu_program_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/alu_program_sequencer.sv
// Stored-program sequencer: fetches 16-bit instructions from a synchronous ROM and
// steps them through the register-file/ALU datapath, four cycles per instruction.
module alu_program_sequencer #(
   parameter int          PC_W       = 4,
   parameter int          PROG_LEN   = 16,
   parameter logic [15:0] HALT_INSTR = 16'hFFFF,
   parameter int          CNT_W      = 8
) (
   input  logic             clk_50M,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   output logic             imem_en,
   output logic [PC_W-1:0]  imem_addr,
   input  logic [15:0]      imem_data,
   output logic [3:0]       rf_sr1,
   output logic [3:0]       rf_sr2,
   output logic [3:0]       rf_dr,
   output logic             rf_we,
   output logic             alu_imm_sel,
   output logic [3:0]       alu_imm,
   output logic [1:0]       alu_op,
   input  logic [15:0]      alu_result,
   input  logic             alu_of,
   output logic [15:0]      disp_data,
   output logic             disp_valid,
   output logic             busy,
   output logic             done,
   output logic             ovf_err,
   output logic [CNT_W-1:0] instr_cnt
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_LOAD  = 3'd2;
   localparam logic [2:0] S_EXEC  = 3'd3;
   localparam logic [2:0] S_WB    = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;
   localparam logic [2:0] S_ERR   = 3'd6;

   localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN - 1);

   logic [2:0]      state;
   logic [PC_W-1:0] pc;
   logic [15:0]     ir;

   always_ff @(posedge clk_50M or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         pc        <= '0;
         ir        <= '0;
         instr_cnt <= '0;
         disp_data <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               // abort overrides a simultaneous start
               if (start) begin
                  if (abort) begin
                     state <= S_IDLE;
                  end else begin
                     state     <= S_FETCH;
                     pc        <= '0;
                     instr_cnt <= '0;
                  end
               end else if (abort && state == S_IDLE) begin
                  state <= S_IDLE;
               end
            end
            S_FETCH: state <= abort ? S_IDLE : S_LOAD;
            S_LOAD: begin
               if (abort) begin
                  state <= S_IDLE;
               end else begin
                  ir    <= imem_data;
                  state <= (imem_data == HALT_INSTR) ? S_DONE : S_EXEC;
               end
            end
            S_EXEC: begin
               if (abort) begin
                  state <= S_IDLE;
               end else if (alu_of) begin
                  state <= S_ERR;
               end else begin
                  state <= S_WB;
                  if (ir[0]) disp_data <= alu_result;
               end
            end
            S_WB: begin
               // the write strobe of this cycle always completes, so it is counted
               if (instr_cnt != '1) instr_cnt <= instr_cnt + 1'b1;
               if (abort) begin
                  state <= S_IDLE;
               end else if (pc == LAST_PC) begin
                  state <= S_DONE;
               end else begin
                  pc    <= pc + 1'b1;
                  state <= S_FETCH;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign imem_en     = (state == S_FETCH);
   assign imem_addr   = pc;
   assign alu_imm_sel = ir[15];
   assign rf_sr1      = ir[14:11];
   assign rf_sr2      = ir[10:7];
   assign alu_imm     = ir[10:7];
   assign alu_op      = ir[6:5];
   assign rf_dr       = ir[4:1];
   assign rf_we       = (state == S_WB) && !ir[0];
   assign disp_valid  = (state == S_WB) && ir[0];
   assign busy        = (state == S_FETCH) || (state == S_LOAD) ||
                        (state == S_EXEC)  || (state == S_WB);
   assign done        = (state == S_DONE);
   assign ovf_err     = (state == S_ERR);

endmodule
